// File: rtl/nvmain_pkg.sv
// Shared types for the nvmain command issuer: opcode enum, opcode-to-ASCII
// lookup, FSM state type and the FIFO entry layout.
package nvmain_pkg;

  typedef enum logic [3:0] {
    OpALo = 4'd0,
    OpAHi = 4'd1,
    OpCLo = 4'd2,
    OpCHi = 4'd3,
    OpLLo = 4'd4,
    OpLHi = 4'd5,
    OpRLo = 4'd6,
    OpRHi = 4'd7,
    OpWLo = 4'd8,
    OpWHi = 4'd9
  } nvmain_op_e;

  localparam int unsigned NumOps = 10;

  // Opcodes at or above this value are illegal and never stored.
  localparam logic [3:0] OpLimit = 4'd10;

  // Entry i holds the command character for opcode i.
  localparam logic [NumOps-1:0][7:0] OpAsciiLut = {
    8'h57, 8'h77, 8'h52, 8'h72, 8'h4c, 8'h6c, 8'h43, 8'h63, 8'h41, 8'h61
  };

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } issuer_state_e;

  // Character plus the four pass-through operands.
  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic [31:0] arg3;
    logic [7:0]  arg4;
  } cmd_entry_t;

  // Illegal opcodes map to 0; callers never store them.
  function automatic logic [7:0] op_to_ascii(input logic [3:0] op);
    logic [7:0] ch;
    ch = 8'h00;
    for (int unsigned i = 0; i < NumOps; i++) begin
      if (op == 4'(i)) ch = OpAsciiLut[i];
    end
    return ch;
  endfunction

endpackage

// File: rtl/nvmain_cmd_fifo.sv
// Synchronous request FIFO for the command issuer. DEPTH must be a power of
// two so the pointers wrap naturally. No read-through bypass: a push into an
// empty FIFO is only visible at the head on the following cycle.
module nvmain_cmd_fifo
  import nvmain_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  cmd_entry_t wdata_i,
  input  logic       pop_i,
  output cmd_entry_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  cmd_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nvmain_cmd_issuer.sv
// nvmain command issuer: queues opcode requests, maps them to ASCII command
// characters and emits one-cycle command_enable strobes separated by at least
// GAP idle cycles. Define NVMAIN_CMD_STATS_EN to add per-class issue counters
// (stat_rd, stat_wr, stat_other).
module nvmain_cmd_issuer
  import nvmain_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_arg1,
  input  logic [31:0] req_arg2,
  input  logic [31:0] req_arg3,
  input  logic [7:0]  req_arg4,
  output logic        command_enable,
  output logic [7:0]  arg0,
  output logic [31:0] arg1,
  output logic [31:0] arg2,
  output logic [31:0] arg3,
  output logic [7:0]  arg4,
  output logic        busy,
  output logic        err_op
`ifdef NVMAIN_CMD_STATS_EN
  ,
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
  output logic [31:0] stat_other
`endif
);

  localparam logic [3:0] GapLast = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  issuer_state_e state_q, state_d;
  logic [3:0]    gap_q, gap_d;
  cmd_entry_t    out_q;
  logic          err_q;

  logic       accept, push, pop;
  logic       fifo_full, fifo_empty;
  cmd_entry_t wdata, head;

  // Illegal opcodes still complete the handshake so upstream never stalls.
  assign req_ready = !rst && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_op < OpLimit);

  // Opcode mapping happens on the way in so the FIFO holds ready-to-issue data.
  always_comb begin
    wdata      = '0;
    wdata.ch   = op_to_ascii(req_op);
    wdata.arg1 = req_arg1;
    wdata.arg2 = req_arg2;
    wdata.arg3 = req_arg3;
    wdata.arg4 = req_arg4;
  end

  nvmain_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Issue FSM. The head is popped on the edge that enters StIssue, so the
  // registered outputs carry that entry for the whole strobe cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StIssue;
          pop     = 1'b1;
        end
      end
      StIssue: begin
        if (GAP > 0) begin
          state_d = StHold;
          gap_d   = 4'd0;
        end else if (!fifo_empty) begin
          state_d = StIssue;
          pop     = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (gap_q == GapLast) begin
          gap_d = 4'd0;
          if (!fifo_empty) begin
            state_d = StIssue;
            pop     = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = 4'd0;
      end
    endcase
  end

  // FSM state and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Command operands: loaded on pop, held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (pop) begin
      out_q <= head;
    end
  end

  // Illegal-opcode pulse, one cycle after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && (req_op >= OpLimit);
    end
  end

  assign command_enable = (state_q == StIssue);
  assign arg0           = out_q.ch;
  assign arg1           = out_q.arg1;
  assign arg2           = out_q.arg2;
  assign arg3           = out_q.arg3;
  assign arg4           = out_q.arg4;
  assign busy           = !fifo_empty || (state_q != StIdle);
  assign err_op         = err_q;

`ifdef NVMAIN_CMD_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_other_q;

  // Classify each issued command by its character; counters wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_other_q <= '0;
    end else if (command_enable) begin
      if (out_q.ch == 8'h72 || out_q.ch == 8'h52) begin
        stat_rd_q <= stat_rd_q + 32'd1;
      end else if (out_q.ch == 8'h77 || out_q.ch == 8'h57) begin
        stat_wr_q <= stat_wr_q + 32'd1;
      end else begin
        stat_other_q <= stat_other_q + 32'd1;
      end
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_other = stat_other_q;
`else
  // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_nvmain_cmd_issuer.sv
// Directed bench for nvmain_cmd_issuer. Two instances share stimulus: u_dut
// uses the default GAP=2, u_slow uses GAP=15 so its FIFO can be filled while
// it is stuck in HOLD.
module tb_nvmain_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_arg1, req_arg2, req_arg3;
  logic [7:0]  req_arg4;

  logic        a_ready, a_en, a_busy, a_err;
  logic [7:0]  a_arg0, a_arg4;
  logic [31:0] a_arg1, a_arg2, a_arg3;
  logic        b_ready, b_en, b_busy, b_err;
  logic [7:0]  b_arg0, b_arg4;
  logic [31:0] b_arg1, b_arg2, b_arg3;
`ifdef NVMAIN_CMD_STATS_EN
  logic [31:0] a_stat_rd, a_stat_wr, a_stat_other;
  logic [31:0] b_stat_rd, b_stat_wr, b_stat_other;
`endif

  nvmain_cmd_issuer #(.DEPTH(4), .GAP(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready), .req_op(req_op),
    .req_arg1(req_arg1), .req_arg2(req_arg2), .req_arg3(req_arg3), .req_arg4(req_arg4),
    .command_enable(a_en), .arg0(a_arg0), .arg1(a_arg1), .arg2(a_arg2), .arg3(a_arg3),
    .arg4(a_arg4), .busy(a_busy), .err_op(a_err)
`ifdef NVMAIN_CMD_STATS_EN
    , .stat_rd(a_stat_rd), .stat_wr(a_stat_wr), .stat_other(a_stat_other)
`endif
  );

  nvmain_cmd_issuer #(.DEPTH(4), .GAP(15)) u_slow (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
    .req_arg1(req_arg1), .req_arg2(req_arg2), .req_arg3(req_arg3), .req_arg4(req_arg4),
    .command_enable(b_en), .arg0(b_arg0), .arg1(b_arg1), .arg2(b_arg2), .arg3(b_arg3),
    .arg4(b_arg4), .busy(b_busy), .err_op(b_err)
`ifdef NVMAIN_CMD_STATS_EN
    , .stat_rd(b_stat_rd), .stat_wr(b_stat_wr), .stat_other(b_stat_other)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  a0;
    logic [31:0] a1, a2, a3;
    logic [7:0]  a4;
  } strobe_t;

  strobe_t a_q[$];
  strobe_t b_q[$];
  int      err_q[$];
  int      a_busy_cnt = 0;

  // Record strobes, error pulses and busy cycles away from the clock edge.
  always @(negedge clk) begin
    strobe_t s;
    if (a_en) begin
      s = '{cyc, a_arg0, a_arg1, a_arg2, a_arg3, a_arg4};
      a_q.push_back(s);
    end
    if (b_en) begin
      s = '{cyc, b_arg0, b_arg1, b_arg2, b_arg3, b_arg4};
      b_q.push_back(s);
    end
    if (a_err) err_q.push_back(cyc);
    if (a_busy) a_busy_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    a_q.delete();
    b_q.delete();
    err_q.delete();
    a_busy_cnt = 0;
  endtask

  // Ends at posedge+1 with rst low.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Holds the request until u_dut accepts it; acc is the accepting cycle.
  task automatic send(input logic [3:0] op, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] a3, input logic [7:0] a4, output int acc);
    req_op = op; req_arg1 = a1; req_arg2 = a2; req_arg3 = a3; req_arg4 = a4;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ready) begin
        acc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no req_ready expected req_ready=1 within 40 cycles");
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a1, a2, a3;
    logic [7:0]  a4;
    logic [7:0]  exp_ch;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    logic [3:0] fill_ops[5];
    logic [7:0] fill_ch[5];
    logic       rdy[5];

    vecs[0]  = '{4'd2,  32'd384,        32'd191991292, 32'd12331,      8'h58, 8'h63, 1'b0};
    vecs[1]  = '{4'd0,  32'h0000_0001,  32'h0000_0002, 32'h0000_0003,  8'h04, 8'h61, 1'b0};
    vecs[2]  = '{4'd1,  32'hFFFF_FFFF,  32'h8000_0000, 32'h7FFF_FFFF,  8'hFF, 8'h41, 1'b0};
    vecs[3]  = '{4'd3,  32'h1234_5678,  32'h9ABC_DEF0, 32'h0F0F_0F0F,  8'hA5, 8'h43, 1'b0};
    vecs[4]  = '{4'd4,  32'hDEAD_BEEF,  32'h0000_0000, 32'hCAFE_F00D,  8'h00, 8'h6c, 1'b0};
    vecs[5]  = '{4'd5,  32'h5555_AAAA,  32'hAAAA_5555, 32'h0000_FFFF,  8'h5A, 8'h4c, 1'b0};
    vecs[6]  = '{4'd6,  32'h0001_0000,  32'h0100_0000, 32'h0000_0100,  8'h11, 8'h72, 1'b0};
    vecs[7]  = '{4'd7,  32'h0BAD_F00D,  32'hFEED_FACE, 32'h1357_9BDF,  8'h22, 8'h52, 1'b0};
    vecs[8]  = '{4'd8,  32'h2468_ACE0,  32'h1111_1111, 32'h2222_2222,  8'h33, 8'h77, 1'b0};
    vecs[9]  = '{4'd9,  32'h3333_3333,  32'h4444_4444, 32'h5555_5555,  8'h44, 8'h57, 1'b0};
    vecs[10] = '{4'd10, 32'h6666_6666,  32'h7777_7777, 32'h8888_8888,  8'h55, 8'h00, 1'b1};
    vecs[11] = '{4'd15, 32'h9999_9999,  32'hAAAA_AAAA, 32'hBBBB_BBBB,  8'h66, 8'h00, 1'b1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 4'd0; req_arg1 = '0; req_arg2 = '0; req_arg3 = '0; req_arg4 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_cmd_en", 32'(a_en), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_arg0", 32'(a_arg0), 32'd0);
    check("rst_arg1", a_arg1, 32'd0);
    check("rst_arg4", 32'(a_arg4), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-request vectors, each from an idle issuer.
    for (int i = 0; i < 12; i++) begin
      clear_mon();
      send(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].a4, acc);
      idle(8);
      if (!vecs[i].exp_err) begin
        check($sformatf("vec%0d_strobes", i), 32'(a_q.size()), 32'd1);
        check($sformatf("vec%0d_errs", i), 32'(err_q.size()), 32'd0);
        if (a_q.size() > 0) begin
          check($sformatf("vec%0d_latency", i), 32'(a_q[0].cyc - acc), 32'd2);
          check($sformatf("vec%0d_arg0", i), 32'(a_q[0].a0), 32'(vecs[i].exp_ch));
          check($sformatf("vec%0d_arg1", i), a_q[0].a1, vecs[i].a1);
          check($sformatf("vec%0d_arg2", i), a_q[0].a2, vecs[i].a2);
          check($sformatf("vec%0d_arg3", i), a_q[0].a3, vecs[i].a3);
          check($sformatf("vec%0d_arg4", i), 32'(a_q[0].a4), 32'(vecs[i].a4));
        end
      end else begin
        check($sformatf("vec%0d_strobes", i), 32'(a_q.size()), 32'd0);
        check($sformatf("vec%0d_errs", i), 32'(err_q.size()), 32'd1);
        check($sformatf("vec%0d_busy_cycles", i), 32'(a_busy_cnt), 32'd0);
        if (err_q.size() > 0) begin
          check($sformatf("vec%0d_err_cycle", i), 32'(err_q[0] - acc), 32'd1);
        end
      end
    end

    // Back-to-back c then C with GAP=2: strobes three cycles apart.
    clear_mon();
    send(4'd2, 32'd384, 32'd191991292, 32'd12331, 8'h58, acc);
    send(4'd3, 32'd384, 32'd191991292, 32'd12331, 8'h58, acc2);
    idle(10);
    check("b2b_accept_gap", 32'(acc2 - acc), 32'd1);
    check("b2b_strobes", 32'(a_q.size()), 32'd2);
    if (a_q.size() == 2) begin
      check("b2b_first_latency", 32'(a_q[0].cyc - acc), 32'd2);
      check("b2b_spacing", 32'(a_q[1].cyc - a_q[0].cyc), 32'd3);
      check("b2b_arg0_first", 32'(a_q[0].a0), 32'h63);
      check("b2b_arg0_second", 32'(a_q[1].a0), 32'h43);
      check("b2b_arg2_second", a_q[1].a2, 32'd191991292);
    end

    // Reset while in HOLD with three requests still queued.
    clear_mon();
    send(4'd0, 32'h10, 32'h20, 32'h30, 8'h40, acc);
    send(4'd1, 32'h11, 32'h21, 32'h31, 8'h41, acc2);
    send(4'd4, 32'h12, 32'h22, 32'h32, 8'h42, acc2);
    send(4'd5, 32'h13, 32'h23, 32'h33, 8'h43, acc2);
    check("hold_pre_rst_strobes", 32'(a_q.size()), 32'd1);
    check("hold_pre_rst_busy", 32'(a_busy), 32'd1);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("hold_rst_ready", 32'(a_ready), 32'd0);
    check("hold_rst_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12);
    @(negedge clk);
    check("hold_post_strobes", 32'(a_q.size()), 32'd1);
    check("hold_post_busy", 32'(a_busy), 32'd0);
    check("hold_post_arg0", 32'(a_arg0), 32'd0);
    check("hold_post_arg1", a_arg1, 32'd0);
    check("hold_post_arg4", 32'(a_arg4), 32'd0);
    check("hold_post_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;

    // Fill u_slow's FIFO while it sits in its 15-cycle HOLD.
    do_reset();
    clear_mon();
    fill_ops = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
    fill_ch  = '{8'h41, 8'h43, 8'h4c, 8'h52, 8'h57};
    send(4'd0, 32'hA0, 32'hB0, 32'hC0, 8'hD0, acc);
    for (int k = 0; k < 5; k++) begin
      req_op = fill_ops[k];
      req_arg1 = 32'(k + 100);
      req_arg2 = 32'(k + 200);
      req_arg3 = 32'(k + 300);
      req_arg4 = 8'(k + 1);
      req_valid = 1'b1;
      @(negedge clk);
      rdy[k] = b_ready;
      @(posedge clk);
      #1;
    end
    idle(80);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fill_ready%0d", k), 32'(rdy[k]), 32'd1);
    end
    check("fill_ready_full", 32'(rdy[4]), 32'd0);
    check("fill_strobes", 32'(b_q.size()), 32'd5);
    if (b_q.size() == 5) begin
      check("fill_first_arg0", 32'(b_q[0].a0), 32'h61);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("fill_order%0d_arg0", k), 32'(b_q[k + 1].a0), 32'(fill_ch[k]));
        check($sformatf("fill_order%0d_arg1", k), b_q[k + 1].a1, 32'(k + 100));
      end
      check("fill_spacing", 32'(b_q[2].cyc - b_q[1].cyc), 32'd16);
    end
    @(negedge clk);
    check("fill_drained_ready", 32'(b_ready), 32'd1);
    check("fill_drained_busy", 32'(b_busy), 32'd0);
    @(posedge clk);
    #1;

`ifdef NVMAIN_CMD_STATS_EN
    // Issue r, R, w, c and count by class.
    do_reset();
    @(negedge clk);
    check("stat_rd_reset", a_stat_rd, 32'd0);
    check("stat_other_reset", a_stat_other, 32'd0);
    @(posedge clk);
    #1;
    send(4'd6, 32'd1, 32'd2, 32'd3, 8'd4, acc);
    send(4'd7, 32'd1, 32'd2, 32'd3, 8'd4, acc);
    send(4'd8, 32'd1, 32'd2, 32'd3, 8'd4, acc);
    send(4'd2, 32'd1, 32'd2, 32'd3, 8'd4, acc);
    idle(20);
    @(negedge clk);
    check("stat_rd", a_stat_rd, 32'd2);
    check("stat_wr", a_stat_wr, 32'd1);
    check("stat_other", a_stat_other, 32'd1);
    @(posedge clk);
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
